// File: rtl/car_sequencer.sv
// Control-address (CAR) sequencer for the microprogrammed control unit.
// Registers the control ROM address and picks the next one from reset,
// branch, interrupt entry, instruction decode, micro call/return or CAR+1.
// Includes a micro-return stack with sticky overflow/underflow flags.
module car_sequencer #(
    parameter int                      CAR_BITS    = 6,
    parameter int                      STACK_DEPTH = 4,
    parameter int                      SP_BITS     = 3,
    parameter logic [CAR_BITS-1:0]     CAR_0       = '0,
    parameter logic [CAR_BITS-1:0]     CAR_INT0    = 'h30,
    parameter logic [CAR_BITS-1:0]     CAR_INT4    = 'h34
) (
    input  logic                MCLK,
    input  logic                rst,
    input  logic                stall,
    input  logic                INTREQ,
    input  logic                IF,
    input  logic                Br,
    input  logic                CALL,
    input  logic                RET,
    input  logic [CAR_BITS-1:0] CARnew,
    input  logic [CAR_BITS-1:0] CARtarget,
    output logic [CAR_BITS-1:0] CAR,
    output logic [CAR_BITS-1:0] CARnext,
    output logic                int_ack,
    output logic [SP_BITS-1:0]  depth,
    output logic                stk_ovf,
    output logic                stk_unf
);

    // The storage array is addressed by the full stack pointer so no index
    // truncation is needed; entries at or above STACK_DEPTH are never written.
    localparam int                 ARR_SIZE  = 1 << SP_BITS;
    localparam logic [SP_BITS-1:0] DEPTH_MAX = SP_BITS'(STACK_DEPTH);

    logic [CAR_BITS-1:0] stack [ARR_SIZE];
    logic [CAR_BITS-1:0] car_inc;
    logic [SP_BITS-1:0]  depth_next;
    logic                push;
    logic                take_int;
    logic                set_ovf;
    logic                set_unf;

    assign car_inc = CAR + CAR_BITS'(1);

    // Priority selection of the next address and the matching stack action.
    always_comb begin
        CARnext    = car_inc;
        depth_next = depth;
        push       = 1'b0;
        take_int   = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        if (Br) begin
            CARnext    = CAR_0;
            depth_next = '0;
        end else if (INTREQ && IF) begin
            CARnext    = CAR_INT0;
            depth_next = '0;
            take_int   = 1'b1;
        end else if (IF) begin
            CARnext    = CARnew;
            depth_next = '0;
        end else if (RET) begin
            if (depth != '0) begin
                CARnext    = stack[depth - SP_BITS'(1)];
                depth_next = depth - SP_BITS'(1);
            end else begin
                CARnext = CAR_0;
                set_unf = 1'b1;
            end
        end else if (CALL) begin
            CARnext = CARtarget;
            if (depth < DEPTH_MAX) begin
                push       = 1'b1;
                depth_next = depth + SP_BITS'(1);
            end else begin
                set_ovf = 1'b1;
            end
        end
    end

    // CAR, stack pointer, acknowledge pulse and sticky flags.
    always_ff @(posedge MCLK) begin
        if (rst) begin
            CAR     <= CAR_INT4;
            depth   <= '0;
            int_ack <= 1'b0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else if (stall) begin
            int_ack <= 1'b0;
        end else begin
            CAR     <= CARnext;
            depth   <= depth_next;
            int_ack <= take_int;
            stk_ovf <= stk_ovf | set_ovf;
            stk_unf <= stk_unf | set_unf;
        end
    end

    // Return-address storage; contents above depth are don't-care, so no reset.
    always_ff @(posedge MCLK) begin
        if (!rst && !stall && push) begin
            stack[depth] <= car_inc;
        end
    end

endmodule
